// File: rtl/ifu_fetch_engine.sv
// Instruction-fetch front end: PC generation, pipelined in-order imem requests
// tracked in a small in-flight FIFO, and an instruction queue toward decode.
module ifu_fetch_engine #(
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h3000_0000,
  parameter bit          PERF_EN         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] bpu_pc,
  input  logic [31:0] bpu_npc,
  input  logic        bpu_taken,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [31:0] out_pred_pc,
  output logic        out_pred_taken,
  output logic        out_fault,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_redirect_cnt,
  output logic [31:0] perf_drop_cnt
);

  localparam int QA = $clog2(QUEUE_DEPTH);
  localparam int QC = QA + 1;
  localparam int IA = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int IN = 1 << IA;
  localparam int IC = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [31:0] MO_LIM = 32'(MAX_OUTSTANDING);
  localparam logic [31:0] QD_LIM = 32'(QUEUE_DEPTH);

  logic [31:0]   pc_reg;

  // In-flight request metadata, popped in order as responses return
  logic [31:0]   if_pc_mem    [IN];
  logic [31:0]   if_npc_mem   [IN];
  logic          if_taken_mem [IN];
  logic          if_kill_reg  [IN];
  logic [IA-1:0] if_wptr_reg;
  logic [IA-1:0] if_rptr_reg;
  logic [IC-1:0] if_cnt_reg;

  logic [31:0]   q_pc_mem    [QUEUE_DEPTH];
  logic [31:0]   q_pred_mem  [QUEUE_DEPTH];
  logic [31:0]   q_inst_mem  [QUEUE_DEPTH];
  logic          q_taken_mem [QUEUE_DEPTH];
  logic          q_fault_mem [QUEUE_DEPTH];
  logic [QA-1:0] q_wptr_reg;
  logic [QA-1:0] q_rptr_reg;
  logic [QC-1:0] q_cnt_reg;

  logic [31:0] credit_sum;
  logic        issue_fire;
  logic        resp_kill;
  logic        resp_keep;
  logic        resp_drop;
  logic        deq_fire;

  // Killed requests still hold a credit until their response drains
  assign credit_sum     = 32'(if_cnt_reg) + 32'(q_cnt_reg);
  assign imem_req_valid = ~reset & ~redirect_valid & (32'(if_cnt_reg) < MO_LIM) & (credit_sum < QD_LIM);
  assign imem_req_addr  = pc_reg;
  assign bpu_pc         = pc_reg;
  assign issue_fire     = imem_req_valid & imem_req_ready;

  assign resp_kill = if_kill_reg[if_rptr_reg];
  assign resp_keep = imem_resp_valid & ~resp_kill & ~redirect_valid;
  assign resp_drop = imem_resp_valid & (resp_kill | redirect_valid);

  assign out_valid      = (q_cnt_reg != '0) & ~redirect_valid;
  assign out_pc         = q_pc_mem[q_rptr_reg];
  assign out_inst       = q_inst_mem[q_rptr_reg];
  assign out_pred_pc    = q_pred_mem[q_rptr_reg];
  assign out_pred_taken = q_taken_mem[q_rptr_reg];
  assign out_fault      = q_fault_mem[q_rptr_reg];
  assign deq_fire       = out_valid & out_ready & ~stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_reg      <= RESET_PC;
      if_wptr_reg <= '0;
      if_rptr_reg <= '0;
      if_cnt_reg  <= '0;
      q_wptr_reg  <= '0;
      q_rptr_reg  <= '0;
      q_cnt_reg   <= '0;
    end else begin
      if (redirect_valid) begin
        pc_reg <= redirect_pc;
      end else if (issue_fire) begin
        pc_reg <= bpu_npc;
      end
      if (issue_fire) begin
        if_wptr_reg <= if_wptr_reg + IA'(1);
      end
      if (imem_resp_valid) begin
        if_rptr_reg <= if_rptr_reg + IA'(1);
      end
      if_cnt_reg <= if_cnt_reg + IC'(issue_fire) - IC'(imem_resp_valid);
      if (resp_keep) begin
        q_wptr_reg <= q_wptr_reg + QA'(1);
      end
      if (redirect_valid) begin
        q_rptr_reg <= q_wptr_reg;
        q_cnt_reg  <= '0;
      end else begin
        if (deq_fire) begin
          q_rptr_reg <= q_rptr_reg + QA'(1);
        end
        q_cnt_reg <= q_cnt_reg + QC'(resp_keep) - QC'(deq_fire);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (issue_fire) begin
      if_pc_mem[if_wptr_reg]    <= pc_reg;
      if_npc_mem[if_wptr_reg]   <= bpu_npc;
      if_taken_mem[if_wptr_reg] <= bpu_taken;
    end
    if (resp_keep) begin
      q_pc_mem[q_wptr_reg]    <= if_pc_mem[if_rptr_reg];
      q_pred_mem[q_wptr_reg]  <= if_npc_mem[if_rptr_reg];
      q_taken_mem[q_wptr_reg] <= if_taken_mem[if_rptr_reg];
      q_inst_mem[q_wptr_reg]  <= imem_resp_err ? 32'h0 : imem_resp_data;
      q_fault_mem[q_wptr_reg] <= imem_resp_err;
    end
  end

  // Redirect marks every slot stale; a slot is revived only when reissued
  for (genvar gi = 0; gi < IN; gi++) begin : g_kill
    always_ff @(posedge clock) begin
      if (reset) begin
        if_kill_reg[gi] <= 1'b0;
      end else if (redirect_valid) begin
        if_kill_reg[gi] <= 1'b1;
      end else if (issue_fire && (if_wptr_reg == IA'(gi))) begin
        if_kill_reg[gi] <= 1'b0;
      end
    end
  end

  if (PERF_EN) begin : g_perf
    logic [31:0] fetch_cnt_reg;
    logic [31:0] redirect_cnt_reg;
    logic [31:0] drop_cnt_reg;
    always_ff @(posedge clock) begin
      if (reset) begin
        fetch_cnt_reg    <= '0;
        redirect_cnt_reg <= '0;
        drop_cnt_reg     <= '0;
      end else begin
        fetch_cnt_reg    <= fetch_cnt_reg + 32'(deq_fire);
        redirect_cnt_reg <= redirect_cnt_reg + 32'(redirect_valid);
        drop_cnt_reg     <= drop_cnt_reg + 32'(resp_drop);
      end
    end
    assign perf_fetch_cnt    = fetch_cnt_reg;
    assign perf_redirect_cnt = redirect_cnt_reg;
    assign perf_drop_cnt     = drop_cnt_reg;
  end else begin : g_noperf
    assign perf_fetch_cnt    = 32'h0;
    assign perf_redirect_cnt = 32'h0;
    assign perf_drop_cnt     = 32'h0;
  end

  a_resp_has_request: assert property (@(posedge clock) disable iff (reset)
    imem_resp_valid |-> (if_cnt_reg != '0));

endmodule

// File: tb/tb_ifu_fetch_engine.sv
// Bench for ifu_fetch_engine: imem model with variable latency, scoreboard of
// expected queue entries, a phase table plus directed redirect/fault/taken cases.
module tb_ifu_fetch_engine;

  localparam int          QD       = 4;
  localparam int          MO       = 2;
  localparam logic [31:0] RST_PC   = 32'h3000_0000;
  localparam logic [31:0] ERR_ADDR = 32'h3000_0008;
  localparam logic [31:0] TK_PC    = 32'h3000_0010;
  localparam logic [31:0] TK_TGT   = 32'h3000_0040;
  localparam logic [31:0] RD_PC    = 32'h8000_0100;

  logic        clock, reset, redirect_valid, stall, bpu_taken;
  logic [31:0] redirect_pc, bpu_pc, bpu_npc;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid, imem_resp_err;
  logic [31:0] imem_req_addr, imem_resp_data;
  logic        out_valid, out_ready, out_pred_taken, out_fault;
  logic [31:0] out_pc, out_inst, out_pred_pc;
  logic [31:0] perf_fetch_cnt, perf_redirect_cnt, perf_drop_cnt;

  ifu_fetch_engine #(
    .QUEUE_DEPTH(QD), .MAX_OUTSTANDING(MO), .RESET_PC(RST_PC), .PERF_EN(1'b1)
  ) dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .bpu_pc(bpu_pc), .bpu_npc(bpu_npc), .bpu_taken(bpu_taken),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_pred_pc(out_pred_pc), .out_pred_taken(out_pred_taken), .out_fault(out_fault),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_redirect_cnt(perf_redirect_cnt), .perf_drop_cnt(perf_drop_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] npc_fn(input logic [31:0] pc);
    return (pc == TK_PC) ? TK_TGT : pc + 32'd4;
  endfunction

  function automatic logic [31:0] inst_fn(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  assign bpu_npc   = npc_fn(bpu_pc);
  assign bpu_taken = (bpu_pc == TK_PC);

  typedef struct {
    logic [31:0] pc;
    logic        kill;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pred;
    logic [31:0] inst;
    logic        taken;
    logic        fault;
  } exp_t;

  typedef struct {
    int ncyc;
    bit ordy;
    bit stl;
    int lat;
    bit rnd;
    int exp_iss;
    int exp_deq;
  } phase_t;

  pend_t       pend[$];
  exp_t        expq[$];
  int          errors, checks, cyc, lat, deq_cnt, iss_cnt, drops, redirs;
  logic [31:0] model_pc;
  bit          rnd_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic guard(input string name, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timeout_%s: condition not reached (cycle %0d)", name, cyc);
    end
  endtask

  // One clock: check outputs against the model, advance model, drive imem
  task automatic tick();
    exp_t  e;
    pend_t p;
    bit    exp_ov, exp_rv, deq, fire, resp;
    #2;
    exp_ov = (expq.size() != 0) && !redirect_valid;
    exp_rv = !redirect_valid && (pend.size() < MO) && ((expq.size() + pend.size()) < QD);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      e = expq[0];
      chk("out_pc", out_pc, e.pc);
      chk("out_inst", out_inst, e.inst);
      chk("out_pred_pc", out_pred_pc, e.pred);
      chk("out_pred_taken", 32'(out_pred_taken), 32'(e.taken));
      chk("out_fault", 32'(out_fault), 32'(e.fault));
    end
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, model_pc);
    deq  = exp_ov && out_ready && !stall;
    fire = exp_rv && imem_req_ready;
    resp = imem_resp_valid;
    if (deq) begin
      e = expq.pop_front();
      deq_cnt++;
      $display("deq pc=%h inst=%h pred=%h taken=%0d fault=%0d", e.pc, e.inst, e.pred, e.taken, e.fault);
    end
    if (resp && pend.size() != 0) begin
      p = pend.pop_front();
      if (p.kill || redirect_valid) begin
        drops++;
      end else begin
        e.pc    = p.pc;
        e.pred  = npc_fn(p.pc);
        e.taken = (p.pc == TK_PC);
        e.fault = (p.pc == ERR_ADDR);
        e.inst  = e.fault ? 32'h0 : inst_fn(p.pc);
        expq.push_back(e);
      end
    end
    if (redirect_valid) begin
      foreach (pend[i]) pend[i].kill = 1'b1;
      expq.delete();
      model_pc = redirect_pc;
      redirs++;
    end
    if (fire) begin
      pend.push_back('{pc: model_pc, kill: 1'b0, due: cyc + lat});
      model_pc = npc_fn(model_pc);
      iss_cnt++;
    end
    @(posedge clock);
    #1;
    cyc++;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = inst_fn(pend[0].pc);
      imem_resp_err   = (pend[0].pc == ERR_ADDR);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      imem_resp_err   = 1'b0;
    end
    if (rnd_mode) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      stall          = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic chk_perf(input string tag);
    chk({"perf_fetch_", tag}, perf_fetch_cnt, 32'(deq_cnt));
    chk({"perf_redirect_", tag}, perf_redirect_cnt, 32'(redirs));
    chk({"perf_drop_", tag}, perf_drop_cnt, 32'(drops));
  endtask

  phase_t tbl[5];

  initial begin
    int i0, d0, dr0, rd0;
    tbl[0] = '{ncyc: 20, ordy: 1'b0, stl: 1'b0, lat: 1, rnd: 1'b0, exp_iss: QD, exp_deq: 0};
    tbl[1] = '{ncyc: 30, ordy: 1'b1, stl: 1'b0, lat: 1, rnd: 1'b0, exp_iss: -1, exp_deq: 30};
    tbl[2] = '{ncyc: 10, ordy: 1'b1, stl: 1'b1, lat: 1, rnd: 1'b0, exp_iss: -1, exp_deq: 0};
    tbl[3] = '{ncyc: 20, ordy: 1'b1, stl: 1'b0, lat: 2, rnd: 1'b0, exp_iss: -1, exp_deq: -1};
    tbl[4] = '{ncyc: 60, ordy: 1'b1, stl: 1'b0, lat: 3, rnd: 1'b1, exp_iss: -1, exp_deq: -1};

    errors = 0; checks = 0; cyc = 0; lat = 1;
    deq_cnt = 0; iss_cnt = 0; drops = 0; redirs = 0; rnd_mode = 1'b0;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0; imem_resp_err = 1'b0;
    out_ready = 1'b0;
    model_pc = RST_PC;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_req_valid", 32'(imem_req_valid), 32'h0);
    chk("reset_bpu_pc", bpu_pc, RST_PC);
    chk_perf("reset");
    reset = 1'b0;

    for (int k = 0; k < 5; k++) begin
      out_ready = tbl[k].ordy;
      stall     = tbl[k].stl;
      lat       = tbl[k].lat;
      rnd_mode  = tbl[k].rnd;
      i0 = iss_cnt;
      d0 = deq_cnt;
      repeat (tbl[k].ncyc) tick();
      if (tbl[k].exp_iss >= 0) chk($sformatf("phase%0d_issued", k), 32'(iss_cnt - i0), 32'(tbl[k].exp_iss));
      if (tbl[k].exp_deq >= 0) chk($sformatf("phase%0d_dequeued", k), 32'(deq_cnt - d0), 32'(tbl[k].exp_deq));
      chk_perf($sformatf("phase%0d", k));
    end

    // Redirect with two requests outstanding
    rnd_mode = 1'b0; out_ready = 1'b1; stall = 1'b0; imem_req_ready = 1'b1; lat = 3;
    for (int i = 0; i < 50 && pend.size() != 2; i++) tick();
    guard("two_inflight", pend.size() == 2);
    dr0 = drops; rd0 = redirs;
    redirect_valid = 1'b1; redirect_pc = RD_PC;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 50 && expq.size() == 0; i++) tick();
    guard("redirect_refill", expq.size() != 0);
    #1;
    chk("redir_out_pc", out_pc, RD_PC);
    chk("redir_drop_cnt", perf_drop_cnt, 32'(dr0 + 2));
    chk("redir_redirect_cnt", perf_redirect_cnt, 32'(rd0 + 1));

    // Redirect coinciding with a response and a would-be dequeue
    lat = 1;
    for (int i = 0; i < 50 && !(pend.size() == 1 && imem_resp_valid && !pend[0].kill && expq.size() != 0); i++) tick();
    guard("resp_deq_align", pend.size() == 1 && imem_resp_valid && expq.size() != 0);
    d0 = deq_cnt; dr0 = drops; rd0 = redirs;
    redirect_valid = 1'b1; redirect_pc = RST_PC;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("coinc_fetch_cnt", perf_fetch_cnt, 32'(d0));
    chk("coinc_drop_cnt", perf_drop_cnt, 32'(dr0 + 1));
    chk("coinc_redirect_cnt", perf_redirect_cnt, 32'(rd0 + 1));

    // Faulting fetch at ERR_ADDR
    for (int i = 0; i < 40 && !(expq.size() != 0 && expq[0].pc == ERR_ADDR); i++) tick();
    guard("fault_head", expq.size() != 0 && expq[0].pc == ERR_ADDR);
    #1;
    chk("fault_out_pc", out_pc, ERR_ADDR);
    chk("fault_out_fault", 32'(out_fault), 32'h1);
    chk("fault_out_inst", out_inst, 32'h0);

    // Taken prediction, then stall holds the head
    for (int i = 0; i < 40 && !(expq.size() != 0 && expq[0].pc == TK_PC); i++) tick();
    guard("taken_head", expq.size() != 0 && expq[0].pc == TK_PC);
    stall = 1'b1;
    #1;
    chk("taken_pred_pc", out_pred_pc, TK_TGT);
    chk("taken_pred_taken", 32'(out_pred_taken), 32'h1);
    repeat (3) tick();
    #1;
    chk("stall_hold_pc", out_pc, TK_PC);
    stall = 1'b0;
    repeat (10) tick();
    chk_perf("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_engine.md
Name: ifu_fetch_engine

Overview:
Parametrised instruction-fetch front end. Generates sequential/predicted PCs, issues up to MAX_OUTSTANDING pipelined requests on a simple in-order imem request/response port, and buffers returned instructions in a QUEUE_DEPTH-entry queue toward IDU. Supports redirect with stale-response kill, fetch fault tagging and optional perf counters. Sits between the BPU/imem and decode.

Parameters:
QUEUE_DEPTH, 4, instruction queue entries (power of 2, >=2)
MAX_OUTSTANDING, 2, max imem requests in flight (power of 2, >=1)
RESET_PC, 32'h30000000, PC after reset
PERF_EN, 1, enables perf counters (0: counters tie to 0)

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
redirect_valid  in  1  flush + PC redirect (mispredict/trap/fence.i)
redirect_pc  in  32  new fetch PC
stall  in  1  blocks dequeue
bpu_pc  out  32  current fetch PC to predictor
bpu_npc  in  32  predicted next PC (combinational from bpu_pc)
bpu_taken  in  1  prediction taken
imem_req_valid  out  1  request valid
imem_req_ready  in  1  request accepted
imem_req_addr  out  32  fetch address (= bpu_pc)
imem_resp_valid  in  1  response valid (in order, always accepted)
imem_resp_data  in  32  instruction
imem_resp_err  in  1  access fault
out_valid  out  1  queue non-empty
out_ready  in  1  downstream ready
out_pc  out  32  instruction PC
out_inst  out  32  instruction (0 on fault)
out_pred_pc  out  32  predicted next PC
out_pred_taken  out  1  prediction taken
out_fault  out  1  fetch access fault
perf_fetch_cnt  out  32  instructions dequeued
perf_redirect_cnt  out  32  redirects taken
perf_drop_cnt  out  32  stale responses discarded

Behaviour:
- Reset: pc=RESET_PC; queue, in-flight tracker, counters cleared; out_valid=0, imem_req_valid=0. imem side shares reset; no pre-reset response is delivered afterwards.
- Issue: imem_req_valid = ~redirect_valid & (inflight < MAX_OUTSTANDING) & (queue_count + inflight < QUEUE_DEPTH). Combinational; request need not be held (SRAM-style). Fire = valid & ready: pc <= bpu_npc; metadata {pc, bpu_npc, bpu_taken, kill=0} pushed into in-flight FIFO (depth MAX_OUTSTANDING).
- Response: pops in-flight head. kill=0 -> enqueue {pc, pred_pc, pred_taken, data or 0, err}. kill=1 -> discard, perf_drop_cnt+1. Response while inflight==0 is a protocol error (assert).
- Same-cycle issue+response: both proceed; inflight unchanged. Credit check uses pre-update counts.
- Dequeue: fire = out_valid & out_ready & ~stall; outputs are queue head (registered storage, zero-latency read). Simultaneous enqueue+dequeue when full is blocked by credit check; when empty, enqueued entry visible next cycle (min latency req->out_valid = 1 cycle after response).
- Redirect (highest priority): queue cleared; all in-flight entries kill=1; response in same cycle discarded; no issue that cycle; pc <= redirect_pc; next issue earliest next cycle. Killed entries still count in inflight until their response returns. Redirect+dequeue same cycle: dequeue ignored (out_* invalidated).
- Counters wrap modulo 2^32; PERF_EN=0 ties them to 0.
- Pointer/count widths: $clog2(depth)+1; wrap-around of read/write pointers modulo depth.

Test Plan:
- Reset, out_ready=1, imem 1-cycle latency, bpu_npc=pc+4 -> requests 0x30000000,04,08...; out_pc sequence matches, one inst/cycle sustained with MAX_OUTSTANDING=2.
- out_ready=0 for 20 cycles -> exactly QUEUE_DEPTH(4) entries accepted, issue stops; release -> all 4 drain in order, no loss/duplication.
- Two requests in flight, redirect_pc=0x80000100 -> both responses dropped (perf_drop_cnt=2), queue empty, next out_pc=0x80000100.
- Redirect in same cycle as response and dequeue -> response dropped, no out fire counted, perf_redirect_cnt+1.
- imem_resp_err=1 at 0x30000008 -> out_fault=1, out_inst=0, out_pc=0x30000008; neighbours fault=0.
- bpu_taken=1, bpu_npc=0x30000040 at pc 0x30000010 -> out_pred_pc=0x30000040, out_pred_taken=1, next request addr 0x30000040; stall=1 holds head unchanged.
